// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, request-to-send, 11-bit frame, ack check); define PS2_TX_TIMEOUT_EN to add a busy watchdog
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, RELEASE} state_t;
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  state_t r_state, w_next;
  logic [1:0] r_clk_s, r_dat_s;
  logic r_clk_d, r_data_oe;
  logic [7:0] r_data;
  logic [3:0] r_bit;
  logic [IW-1:0] r_inh;
  logic w_clk, w_dat, w_fall, w_inh_done, w_to, w_done, w_err;
  assign w_clk = r_clk_s[1];
  assign w_dat = r_dat_s[1];
  assign w_fall = r_clk_d & ~w_clk;
  assign w_inh_done = r_inh == IW'(INHIBIT_CYCLES - 1);
  assign busy = r_state != IDLE;
  assign ps2_clk_oe = r_state == INHIBIT || r_state == REQ;
  assign ps2_data_oe = r_state == REQ || (r_state == SHIFT && r_data_oe);
  assign done = rst & w_done;
  assign err = rst & w_err;
`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wd;
  // watchdog: cycles spent busy, cleared whenever the block is idle
  always_ff @(posedge clk)
    if (!rst || !busy) r_wd <= '0;
    else r_wd <= r_wd + 1'b1;
  assign w_to = busy && r_wd == TW'(TIMEOUT_CYCLES);
`else
  assign w_to = TIMEOUT_CYCLES < 0;
`endif
  // next state plus done/err pulses; a watchdog expiry overrides any transition
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_err = 1'b0;
    if (w_to) begin
      w_next = IDLE;
      w_err = 1'b1;
    end else
      case (r_state)
        IDLE:    w_next = tx_start ? INHIBIT : IDLE;
        INHIBIT: w_next = w_inh_done ? REQ : INHIBIT;
        REQ:     w_next = SHIFT;
        SHIFT:   w_next = (w_fall && r_bit == 4'd9) ? ACK : SHIFT;
        ACK: if (w_fall) begin
          w_next = w_dat ? IDLE : RELEASE;
          w_err = w_dat;
        end
        RELEASE: if (w_clk && w_dat) begin
          w_next = IDLE;
          w_done = 1'b1;
        end
        default: w_next = IDLE;
      endcase
  end
  // state, line synchronizers, byte latch, counters and the bit being driven
  always_ff @(posedge clk)
    if (!rst) begin
      r_state <= IDLE;
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
      r_clk_d <= 1'b1;
      r_data <= '0;
      r_bit <= '0;
      r_inh <= '0;
      r_data_oe <= 1'b0;
    end else begin
      r_state <= w_next;
      r_clk_s <= {r_clk_s[0], ps2_clk_i};
      r_dat_s <= {r_dat_s[0], ps2_data_i};
      r_clk_d <= w_clk;
      if (r_state == IDLE && tx_start) r_data <= tx_data;
      r_inh <= (r_state == INHIBIT && !w_inh_done) ? r_inh + 1'b1 : '0;
      r_bit <= (r_state == SHIFT || r_state == ACK) ? r_bit + {3'b000, w_fall} : 4'd0;
      if (r_state == REQ) r_data_oe <= 1'b1;
      else if (r_state == SHIFT && w_fall)
        r_data_oe <= r_bit < 4'd8 ? ~r_data[r_bit[2:0]] : r_bit == 4'd8 ? ^r_data : 1'b0;
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model with a frame scoreboard for ps2_host_tx
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TO = 1000;
  localparam int HALF = 10;
  logic clk = 1'b0, rst = 1'b0, tx_start = 1'b0, dev_clk = 1'b1, dev_data = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe, busy, done, err;
  logic last_err = 1'b0;
  int n_tests = 0, n_fail = 0, n_done = 0, n_err = 0, n_both = 0, n_err_busy = 0;
  logic [9:0] exp_q[$];

  assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) n_done++;
    if (err === 1'b1) n_err++;
    if (done === 1'b1 && err === 1'b1) n_both++;
    if (last_err && busy !== 1'b0) n_err_busy++;
    last_err = (err === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic start_xfer(input logic [7:0] d, output logic b0, output int inh, output int req);
    int t = 0;
    @(negedge clk);
    tx_data = d;
    tx_start = 1'b1;
    exp_q.push_back({1'b1, ~^d, d});
    @(negedge clk);
    tx_start = 1'b0;
    tx_data = ~d;
    b0 = busy;
    inh = 0;
    req = 0;
    while (ps2_clk_oe === 1'b1 && t < INH + 50) begin
      inh++;
      if (ps2_data_oe === 1'b1) req++;
      @(negedge clk);
      t++;
    end
  endtask

  task automatic device_xfer(input logic ack, input int poke_edge, input int rst_edge,
                             output logic [9:0] frame, output logic start_bit, output logic ok);
    int t = 0;
    frame = '0;
    start_bit = 1'b1;
    ok = 1'b0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) return;
    ok = 1'b1;
    repeat (6) @(negedge clk);
    start_bit = ps2_data_i;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) begin
        dev_data = ~ack;
        repeat (4) @(negedge clk);
      end
      dev_clk = 1'b0;
      if (k == poke_edge) begin
        tx_data = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
      if (k == rst_edge) begin
        repeat (HALF / 2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dev_clk = 1'b1;
        dev_data = 1'b1;
        return;
      end
      repeat (HALF) @(negedge clk);
      if (k <= 10) frame[k-1] = ps2_data_i;
      dev_clk = 1'b1;
      if (k == 11) dev_data = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe); end
    n_tests++; if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe: got %b expected 0", ps2_data_oe); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got done=%b err=%b expected 0 0", done, err); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got busy=%b clk_oe=%b expected 0 0", busy, ps2_clk_oe); end
  endtask

  task automatic test_f4();
    logic [9:0] fr, ex;
    logic sb, ok, b0;
    int inh, req, d0, e0, t;
    d0 = n_done;
    e0 = n_err;
    start_xfer(8'hF4, b0, inh, req);
    n_tests++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL f4_busy_rise: got %b expected 1", b0); end
    n_tests++; if (inh != INH + 1) begin n_fail++; $display("FAIL f4_inhibit_len: got %0d expected %0d", inh, INH + 1); end
    n_tests++; if (req != 1) begin n_fail++; $display("FAIL f4_req_len: got %0d expected 1", req); end
    device_xfer(1'b1, 0, 0, fr, sb, ok);
    ex = exp_q.pop_front();
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL f4_request: got %b expected 1", ok); end
    n_tests++; if (sb !== 1'b0) begin n_fail++; $display("FAIL f4_start_bit: got %b expected 0", sb); end
    n_tests++; if (fr[7:0] !== ex[7:0]) begin n_fail++; $display("FAIL f4_data: got %h expected %h", fr[7:0], ex[7:0]); end
    n_tests++; if (fr[8] !== 1'b0) begin n_fail++; $display("FAIL f4_parity: got %b expected 0", fr[8]); end
    n_tests++; if (fr[9] !== 1'b1) begin n_fail++; $display("FAIL f4_stop: got %b expected 1", fr[9]); end
    t = 0;
    while (n_done == d0 && t < 50) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    n_tests++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL f4_done_cycles: got %0d expected 1", n_done - d0); end
    n_tests++; if (n_err != e0) begin n_fail++; $display("FAIL f4_err: got %0d expected %0d", n_err, e0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL f4_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_parity_ff();
    logic [9:0] fr, ex;
    logic sb, ok, b0;
    int inh, req, d0, t;
    d0 = n_done;
    start_xfer(8'hFF, b0, inh, req);
    device_xfer(1'b1, 0, 0, fr, sb, ok);
    ex = exp_q.pop_front();
    n_tests++; if (fr[8] !== 1'b1) begin n_fail++; $display("FAIL ff_parity: got %b expected 1", fr[8]); end
    n_tests++; if (fr !== ex) begin n_fail++; $display("FAIL ff_frame: got %h expected %h", fr, ex); end
    t = 0;
    while (n_done == d0 && t < 50) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    n_tests++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL ff_done: got %0d expected 1", n_done - d0); end
  endtask

  task automatic test_nack();
    logic [9:0] fr, ex;
    logic sb, ok, b0;
    int inh, req, d0, e0, eb0;
    d0 = n_done;
    e0 = n_err;
    eb0 = n_err_busy;
    start_xfer(8'h3C, b0, inh, req);
    device_xfer(1'b0, 0, 0, fr, sb, ok);
    ex = exp_q.pop_front();
    repeat (10) @(negedge clk);
    n_tests++; if (fr !== ex) begin n_fail++; $display("FAIL nack_frame: got %h expected %h", fr, ex); end
    n_tests++; if (n_err - e0 != 1) begin n_fail++; $display("FAIL nack_err_cycles: got %0d expected 1", n_err - e0); end
    n_tests++; if (n_err_busy != eb0) begin n_fail++; $display("FAIL nack_busy_after_err: got %0d expected %0d", n_err_busy, eb0); end
    n_tests++; if (n_done != d0) begin n_fail++; $display("FAIL nack_done: got %0d expected %0d", n_done, d0); end
  endtask

  task automatic test_ignore_start();
    logic [9:0] fr, ex;
    logic sb, ok, b0;
    int inh, req, d0, t;
    d0 = n_done;
    start_xfer(8'h5A, b0, inh, req);
    device_xfer(1'b1, 4, 0, fr, sb, ok);
    ex = exp_q.pop_front();
    n_tests++; if (fr[7:0] !== 8'h5A || fr !== ex) begin n_fail++; $display("FAIL ignore_frame: got %h expected %h", fr, ex); end
    t = 0;
    while (n_done == d0 && t < 50) begin @(negedge clk); t++; end
    repeat (40) @(negedge clk);
    n_tests++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL ignore_done: got %0d expected 1", n_done - d0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_restart: got busy=%b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] fr, ex;
    logic sb, ok, b0;
    logic [7:0] d;
    int inh, req, d0, t;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(0, 255));
      d0 = n_done;
      start_xfer(d, b0, inh, req);
      device_xfer(1'b1, 0, 0, fr, sb, ok);
      ex = exp_q.pop_front();
      n_tests++; if (fr !== ex) begin n_fail++; $display("FAIL b2b_frame[%0d]: got %h expected %h", i, fr, ex); end
      t = 0;
      while (n_done == d0 && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
      n_tests++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL b2b_done[%0d]: got %0d expected 1", i, n_done - d0); end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] fr, ex;
    logic sb, ok, b0;
    int inh, req, d0, e0;
    d0 = n_done;
    e0 = n_err;
    start_xfer(8'hC3, b0, inh, req);
    device_xfer(1'b1, 0, 6, fr, sb, ok);
    ex = exp_q.pop_front();
    n_tests++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_lines: got clk_oe=%b data_oe=%b expected 0 0", ps2_clk_oe, ps2_data_oe); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0 (frame %h)", busy, ex); end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    n_tests++; if (n_done != d0 || n_err != e0) begin n_fail++; $display("FAIL rstmid_pulses: got done=%0d err=%0d expected 0 0", n_done - d0, n_err - e0); end
    test_f4();
  endtask

`ifdef PS2_TX_TIMEOUT_EN
  task automatic test_timeout();
    int t, e0;
    e0 = n_err;
    @(negedge clk);
    tx_data = 8'hF4;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    t = 0;
    while (err !== 1'b1 && t < 2 * TO) begin @(negedge clk); t++; end
    n_tests++; if (t != TO) begin n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", t, TO); end
    @(negedge clk);
    n_tests++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_release: got clk_oe=%b data_oe=%b busy=%b expected 0 0 0", ps2_clk_oe, ps2_data_oe, busy); end
    repeat (3) @(negedge clk);
    n_tests++; if (n_err - e0 != 1) begin n_fail++; $display("FAIL timeout_err_cycles: got %0d expected 1", n_err - e0); end
  endtask
`else
  task automatic test_timeout();
    int e0;
    e0 = n_err;
    @(negedge clk);
    tx_data = 8'hF4;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (TO + 500) @(negedge clk);
    n_tests++; if (busy !== 1'b1 || ps2_data_oe !== 1'b1) begin n_fail++; $display("FAIL nowd_waiting: got busy=%b data_oe=%b expected 1 1", busy, ps2_data_oe); end
    n_tests++; if (n_err != e0) begin n_fail++; $display("FAIL nowd_err: got %0d expected %0d", n_err - e0, 0); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL nowd_recover: got busy=%b data_oe=%b expected 0 0", busy, ps2_data_oe); end
  endtask
`endif

  initial begin
    test_reset();
    test_f4();
    test_parity_ff();
    test_nack();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    n_tests++; if (n_both != 0) begin n_fail++; $display("FAIL done_err_overlap: got %0d expected 0", n_both); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d expected 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
